// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - measures high width and rising-to-rising period of a pulse train
// Optional input synchronizer: define PULSE_METER_SYNC_EN.
module pulse_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  output logic [WIDTH-1:0] width,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             ovf,
  output logic             active
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             sig_s;
  logic             x;
  logic             xp;
  logic             rise;
  logic             fall;
  logic [1:0]       state;
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] hcnt_inc;
  logic [WIDTH-1:0] pcnt_inc;
  logic             hcnt_sat;
  logic             pcnt_sat;
  logic             ovf_acc;

`ifdef PULSE_METER_SYNC_EN
  logic [1:0] sync_q;

  // Synchronizer idles high so a line already high at reset release is not a rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], signal};
    end
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = signal;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x  <= 1'b1;
      xp <= 1'b1;
    end else begin
      x  <= sig_s;
      xp <= x;
    end
  end

  assign rise = x & ~xp;
  assign fall = ~x & xp;

  assign hcnt_sat = (hcnt == CNT_MAX);
  assign pcnt_sat = (pcnt == CNT_MAX);
  assign hcnt_inc = hcnt_sat ? hcnt : hcnt + CNT_ONE;
  assign pcnt_inc = pcnt_sat ? pcnt : pcnt + CNT_ONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hcnt    <= '0;
      pcnt    <= '0;
      ovf_acc <= 1'b0;
      width   <= '0;
      period  <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            hcnt    <= CNT_ONE;
            pcnt    <= CNT_ONE;
            ovf_acc <= 1'b0;
          end
        end
        HIGH: begin
          pcnt <= pcnt_inc;
          if (pcnt_sat) ovf_acc <= 1'b1;
          if (fall) begin
            state <= LOW;
          end else begin
            hcnt <= hcnt_inc;
            if (hcnt_sat) ovf_acc <= 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            width   <= hcnt;
            period  <= pcnt;
            ovf     <= ovf_acc;
            valid   <= 1'b1;
            state   <= HIGH;
            hcnt    <= CNT_ONE;
            pcnt    <= CNT_ONE;
            ovf_acc <= 1'b0;
          end else begin
            pcnt <= pcnt_inc;
            if (pcnt_sat) ovf_acc <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_pulse_meter.sv
// tb/tb_pulse_meter.sv - directed self-checking bench for pulse_meter
module tb_pulse_meter;

  logic       clock;
  logic       reset;
  logic       signal;
  logic [7:0] width;
  logic [7:0] period;
  logic       valid;
  logic       ovf;
  logic       active;

  int n_vec;
  int n_err;
  int n_strobe;
  int cyc;
  int last_cyc;
  int last_gap;
  int last_w;
  int last_p;
  int last_o;
  int base;
  logic vq [1:8];

`ifdef PULSE_METER_SYNC_EN
  localparam int D = 4;
`else
  localparam int D = 2;
`endif

  pulse_meter #(.WIDTH(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .signal (signal),
    .width  (width),
    .period (period),
    .valid  (valid),
    .ovf    (ovf),
    .active (active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (valid) begin
      n_strobe = n_strobe + 1;
      last_w   = int'(width);
      last_p   = int'(period);
      last_o   = int'(ovf);
      last_gap = cyc - last_cyc;
      last_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v);
    signal = v;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_strobe = 0; cyc = 0; last_cyc = 0; last_gap = 0;
    last_w = 0; last_p = 0; last_o = 0;
    reset  = 1'b1;
    signal = 1'b1;
    #2;
    check("reset_width",  int'(width),  0);
    check("reset_period", int'(period), 0);
    check("reset_valid",  int'(valid),  0);
    check("reset_ovf",    int'(ovf),    0);
    check("reset_active", int'(active), 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // line high through reset release: no edge, no activity
    drive(1'b1, 20);
    check("idle_high_strobes", n_strobe, 0);
    check("idle_high_active",  int'(active), 0);
    drive(1'b0, 5);
    check("idle_low_active", int'(active), 0);

    // 3 high / 9 low, four periods; fourth rise stepped manually for latency
    base = n_strobe;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3);
      drive(1'b0, 9);
    end
    check("train_active", int'(active), 1);
    for (int j = 1; j <= 6; j++) begin
      step(j <= 3);
      vq[j] = valid;
    end
    drive(1'b0, 6);
    check("train_strobes", n_strobe - base, 3);
    check("train_width",  last_w, 3);
    check("train_period", last_p, 12);
    check("train_ovf",    last_o, 0);
    check("lat_before",   int'(vq[D-1]), 0);
    check("lat_at",       int'(vq[D]),   1);
    check("lat_after",    int'(vq[D+1]), 0);
    check("hold_width",   int'(width),  3);
    check("hold_period",  int'(period), 12);

    // minimum train 1 high / 1 low
    base = n_strobe;
    for (int k = 0; k < 6; k++) begin
      step(1'b1);
      step(1'b0);
    end
    drive(1'b0, 4);
    check("min_strobes", n_strobe - base, 6);
    check("min_width",   last_w, 1);
    check("min_period",  last_p, 2);
    check("min_gap",     last_gap, 2);

    // saturation, then a normal period clears ovf
    drive(1'b1, 300);
    drive(1'b0, 10);
    drive(1'b1, 3);
    drive(1'b0, 9);
    check("sat_width",  last_w, 255);
    check("sat_period", last_p, 255);
    check("sat_ovf",    last_o, 1);
    drive(1'b1, 3);
    drive(1'b0, 2);
    check("post_sat_width",  last_w, 3);
    check("post_sat_period", last_p, 12);
    check("post_sat_ovf",    last_o, 0);

    // asynchronous reset in the middle of a high phase
    drive(1'b0, 7);
    drive(1'b1, 5);
    #3 reset = 1'b1;
    #1;
    check("mid_reset_width",  int'(width),  0);
    check("mid_reset_period", int'(period), 0);
    check("mid_reset_valid",  int'(valid),  0);
    check("mid_reset_ovf",    int'(ovf),    0);
    check("mid_reset_active", int'(active), 0);
    #1 reset = 1'b0;
    base = n_strobe;
    drive(1'b1, 1);
    drive(1'b0, 9);
    check("post_reset_active0", int'(active), 0);
    drive(1'b1, 3);
    drive(1'b0, 9);
    check("post_reset_first_rise", n_strobe - base, 0);
    check("post_reset_active1", int'(active), 1);
    drive(1'b1, 3);
    drive(1'b0, 5);
    check("post_reset_strobes", n_strobe - base, 1);
    check("post_reset_width",   last_w, 3);
    check("post_reset_period",  last_p, 12);
    check("post_reset_ovf",     last_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
